// File: rtl/ssg_scan_decoder_pkg.sv
// Shared seven-segment bus constants (same values the display encoder drives)
// and the per-dwell FSM state type for the scan decoder.
package ssg_scan_decoder_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SSG_0     = 7'b1000000;
  localparam logic [6:0] SSG_1     = 7'b1111001;
  localparam logic [6:0] SSG_2     = 7'b0100100;
  localparam logic [6:0] SSG_3     = 7'b0110000;
  localparam logic [6:0] SSG_4     = 7'b0011001;
  localparam logic [6:0] SSG_5     = 7'b0010010;
  localparam logic [6:0] SSG_6     = 7'b0000010;
  localparam logic [6:0] SSG_7     = 7'b1111000;
  localparam logic [6:0] SSG_8     = 7'b0000000;
  localparam logic [6:0] SSG_9     = 7'b0010000;
  localparam logic [6:0] SSG_DASH  = 7'b0111111;
  localparam logic [6:0] SSG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_ERR   = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [3:0] AN_POS0 = 4'b1110;
  localparam logic [3:0] AN_POS1 = 4'b1101;
  localparam logic [3:0] AN_POS2 = 4'b1011;
  localparam logic [3:0] AN_POS3 = 4'b0111;
  localparam logic [3:0] AN_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SETTLED = 2'd1,
    ST_HELD    = 2'd2
  } dwell_state_e;

  function automatic logic is_numeral(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/ssg_scan_decoder_pattern_decode.sv
// Combinational seven-segment pattern to digit-code decoder; unknown
// patterns map to CODE_ERR with the invalid flag raised.
module ssg_pattern_decode
  import ssg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  // Table lookup of the active-low segment pattern
  always_comb begin
    code    = CODE_ERR;
    invalid = 1'b0;
    case (seg)
      SSG_0:     code = 4'd0;
      SSG_1:     code = 4'd1;
      SSG_2:     code = 4'd2;
      SSG_3:     code = 4'd3;
      SSG_4:     code = 4'd4;
      SSG_5:     code = 4'd5;
      SSG_6:     code = 4'd6;
      SSG_7:     code = 4'd7;
      SSG_8:     code = 4'd8;
      SSG_9:     code = 4'd9;
      SSG_DASH:  code = CODE_DASH;
      SSG_BLANK: code = CODE_BLANK;
      default: begin
        code    = CODE_ERR;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ssg_scan_decoder.sv
// Receive-side monitor for the multiplexed 4-digit seven-segment bus: settles,
// captures each scanned position and emits one reconstructed frame per scan.
module ssg_scan_decoder
  import ssg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] value_bin,
  output logic       value_valid,
  output logic [3:0] dash_mask,
  output logic [3:0] dp_mask,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       anode_err,
  output logic       scan_active
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [11:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [SW-1:0]    stable_cnt_q, stable_cnt_d;
  dwell_state_e     state_q, state_d;
  logic [3:0][3:0]  code_q, code_d;
  logic [3:0]       dp_reg_q, dp_reg_d, mask_q, mask_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [3:0]       ones_q, ones_d, tens_q, tens_d, dash_mask_q, dash_mask_d, dp_mask_q, dp_mask_d;
  logic [6:0]       value_bin_q, value_bin_d;
  logic             value_valid_q, value_valid_d, frame_valid_q, frame_valid_d;
  logic             seg_err_q, seg_err_d, anode_err_q, anode_err_d, scan_active_q, scan_active_d;

  logic             changed_s, capture_s, pos_hit_s, anode_bad_s, dec_invalid_s;
  logic [1:0]       pos_idx_s;
  logic [3:0]       dec_code_s, s_an;
  logic [6:0]       s_seg;
  logic             s_dp;

  assign s_an      = sync2_q[11:8];
  assign s_seg     = sync2_q[7:1];
  assign s_dp      = sync2_q[0];
  assign changed_s = (sync2_q != prev_q);

  ssg_pattern_decode u_decode (
    .seg     (s_seg),
    .code    (dec_code_s),
    .invalid (dec_invalid_s)
  );

  // Synchronizer, settle counter and dwell FSM next-state
  always_comb begin
    sync1_d   = {an, seg, dp};
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    capture_s = 1'b0;
    if (changed_s) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q != SETTLE_MAX) begin
      stable_cnt_d = stable_cnt_q + SW'(1);
    end else begin
      stable_cnt_d = stable_cnt_q;
    end
    case (state_q)
      ST_WAIT: begin
        if (stable_cnt_d == SETTLE_MAX) begin
          state_d   = ST_SETTLED;
          capture_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SETTLED: state_d = changed_s ? ST_WAIT : ST_HELD;
      ST_HELD:    state_d = changed_s ? ST_WAIT : ST_HELD;
      default:    state_d = ST_WAIT;
    endcase
  end

  // Which anode position the settled bus addresses
  always_comb begin
    pos_hit_s   = 1'b0;
    pos_idx_s   = 2'd0;
    anode_bad_s = 1'b0;
    case (s_an)
      AN_POS0: begin pos_hit_s = 1'b1; pos_idx_s = 2'd0; end
      AN_POS1: begin pos_hit_s = 1'b1; pos_idx_s = 2'd1; end
      AN_POS2: begin pos_hit_s = 1'b1; pos_idx_s = 2'd2; end
      AN_POS3: begin pos_hit_s = 1'b1; pos_idx_s = 2'd3; end
      AN_NONE: pos_hit_s = 1'b0;
      default: anode_bad_s = 1'b1;
    endcase
  end

  // Capture, frame assembly and scan timeout
  always_comb begin
    code_d        = code_q;
    dp_reg_d      = dp_reg_q;
    mask_d        = mask_q;
    tmo_d         = tmo_q;
    scan_active_d = scan_active_q;
    ones_d        = ones_q;
    tens_d        = tens_q;
    value_bin_d   = value_bin_q;
    value_valid_d = value_valid_q;
    dash_mask_d   = dash_mask_q;
    dp_mask_d     = dp_mask_q;
    frame_valid_d = 1'b0;
    seg_err_d     = 1'b0;
    anode_err_d   = 1'b0;
    if (capture_s && pos_hit_s) begin
      code_d[pos_idx_s]   = dec_code_s;
      dp_reg_d[pos_idx_s] = s_dp;
      mask_d[pos_idx_s]   = 1'b1;
      seg_err_d           = dec_invalid_s;
      tmo_d               = '0;
      scan_active_d       = 1'b1;
      if (mask_d == 4'b1111) begin
        frame_valid_d = 1'b1;
        mask_d        = 4'b0000;
        ones_d        = code_d[0];
        tens_d        = code_d[1];
        dp_mask_d     = dp_reg_d;
        for (int i = 0; i < 4; i++) begin
          dash_mask_d[i] = (code_d[i] == CODE_DASH);
        end
        if (is_numeral(code_d[0]) && is_numeral(code_d[1])) begin
          value_valid_d = 1'b1;
          value_bin_d   = ({3'b000, code_d[1]} * 7'd10) + {3'b000, code_d[0]};
        end else begin
          value_valid_d = 1'b0;
          value_bin_d   = 7'd0;
        end
      end else begin
        frame_valid_d = 1'b0;
      end
    end else begin
      anode_err_d = capture_s && anode_bad_s;
      // Saturate at the limit so an idle bus keeps the partial frame discarded
      if (tmo_q >= TIMEOUT_MAX - TW'(1)) begin
        tmo_d         = TIMEOUT_MAX;
        mask_d        = 4'b0000;
        scan_active_d = 1'b0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q       <= 12'hFFF;
      sync2_q       <= 12'hFFF;
      prev_q        <= 12'hFFF;
      stable_cnt_q  <= '0;
      state_q       <= ST_WAIT;
      code_q        <= {4{CODE_BLANK}};
      dp_reg_q      <= 4'b0000;
      mask_q        <= 4'b0000;
      tmo_q         <= '0;
      scan_active_q <= 1'b0;
      ones_q        <= 4'hF;
      tens_q        <= 4'hF;
      value_bin_q   <= 7'd0;
      value_valid_q <= 1'b0;
      dash_mask_q   <= 4'b0000;
      dp_mask_q     <= 4'b0000;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      stable_cnt_q  <= stable_cnt_d;
      state_q       <= state_d;
      code_q        <= code_d;
      dp_reg_q      <= dp_reg_d;
      mask_q        <= mask_d;
      tmo_q         <= tmo_d;
      scan_active_q <= scan_active_d;
      ones_q        <= ones_d;
      tens_q        <= tens_d;
      value_bin_q   <= value_bin_d;
      value_valid_q <= value_valid_d;
      dash_mask_q   <= dash_mask_d;
      dp_mask_q     <= dp_mask_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      anode_err_q   <= anode_err_d;
    end
  end

  assign ones        = ones_q;
  assign tens        = tens_q;
  assign value_bin   = value_bin_q;
  assign value_valid = value_valid_q;
  assign dash_mask   = dash_mask_q;
  assign dp_mask     = dp_mask_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign anode_err   = anode_err_q;
  assign scan_active = scan_active_q;

endmodule

// File: tb/tb_ssg_scan_decoder.sv
// Directed, table-driven bench for ssg_scan_decoder: full-scan vectors plus
// hand sequences for settle timing, anode errors, timeout and mid-frame reset.
module tb_ssg_scan_decoder;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0010000, PD = 7'b0111111, PB = 7'b1111111;
  localparam logic [6:0] PBAD = 7'b1010101;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111, AI = 4'b1111;
  localparam int DWELL = 32;

  logic clock, reset, dp_i, value_valid, frame_valid, seg_err, anode_err, scan_active;
  logic [6:0] seg_i, value_bin;
  logic [3:0] an_i, ones, tens, dash_mask, dp_mask;

  int checks = 0, failures = 0;
  int fv_cnt = 0, se_cnt = 0, ae_cnt = 0;
  int fv_snap, se_snap, ae_snap, n;

  typedef struct {
    logic [6:0]  s0, s1, s2, s3;
    logic [3:0]  dpv, e_ones, e_tens;
    logic [6:0]  e_val;
    logic        e_vv;
    logic [3:0]  e_dash;
    logic [31:0] e_serr;
  } vec_t;
  vec_t vecs [6];

  ssg_scan_decoder dut (
    .clock(clock), .reset(reset), .seg(seg_i), .dp(dp_i), .an(an_i),
    .ones(ones), .tens(tens), .value_bin(value_bin), .value_valid(value_valid),
    .dash_mask(dash_mask), .dp_mask(dp_mask), .frame_valid(frame_valid),
    .seg_err(seg_err), .anode_err(anode_err), .scan_active(scan_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters, sampled away from the active edge
  always @(negedge clock) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (seg_err)     se_cnt <= se_cnt + 1;
    if (anode_err)   ae_cnt <= ae_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int cyc);
    an_i = a; seg_i = s; dp_i = d;
    repeat (cyc) @(negedge clock);
  endtask

  task automatic scan4(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpv);
    hold(A0, s0, dpv[0], DWELL);
    hold(A1, s1, dpv[1], DWELL);
    hold(A2, s2, dpv[2], DWELL);
    hold(A3, s3, dpv[3], DWELL);
  endtask

  task automatic snap();
    fv_snap = fv_cnt; se_snap = se_cnt; ae_snap = ae_cnt;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ones"}, 32'(ones), 32'hF);
    check({tag, "_tens"}, 32'(tens), 32'hF);
    check({tag, "_val"}, 32'(value_bin), 32'd0);
    check({tag, "_vv"}, 32'(value_valid), 32'd0);
    check({tag, "_dash"}, 32'(dash_mask), 32'd0);
    check({tag, "_dp"}, 32'(dp_mask), 32'd0);
    check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    check({tag, "_active"}, 32'(scan_active), 32'd0);
  endtask

  initial begin
    vecs[0] = '{P9, P2, PD, PD, 4'b0000, 4'd9, 4'd2, 7'd29, 1'b1, 4'b1100, 32'd0};
    vecs[1] = '{P0, P3, P8, PB, 4'b0101, 4'd0, 4'd3, 7'd30, 1'b1, 4'b0000, 32'd0};
    vecs[2] = '{P7, PD, P1, P6, 4'b0000, 4'd7, 4'hA, 7'd0, 1'b0, 4'b0010, 32'd0};
    vecs[3] = '{P4, PBAD, P5, P5, 4'b1000, 4'd4, 4'hE, 7'd0, 1'b0, 4'b0000, 32'd1};
    vecs[4] = '{PB, PB, PD, P9, 4'b0000, 4'hF, 4'hF, 7'd0, 1'b0, 4'b0100, 32'd0};
    vecs[5] = '{P9, P9, P0, PD, 4'b0010, 4'd9, 4'd9, 7'd99, 1'b1, 4'b1000, 32'd0};

    reset = 1'b1; an_i = AI; seg_i = PB; dp_i = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_state("por");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      snap();
      scan4(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].dpv);
      check($sformatf("v%0d_frames", i), 32'(fv_cnt - fv_snap), 32'd1);
      check($sformatf("v%0d_ones", i), 32'(ones), 32'(vecs[i].e_ones));
      check($sformatf("v%0d_tens", i), 32'(tens), 32'(vecs[i].e_tens));
      check($sformatf("v%0d_val", i), 32'(value_bin), 32'(vecs[i].e_val));
      check($sformatf("v%0d_vv", i), 32'(value_valid), 32'(vecs[i].e_vv));
      check($sformatf("v%0d_dash", i), 32'(dash_mask), 32'(vecs[i].e_dash));
      check($sformatf("v%0d_dp", i), 32'(dp_mask), 32'(vecs[i].dpv));
      check($sformatf("v%0d_segerr", i), 32'(se_cnt - se_snap), vecs[i].e_serr);
      check($sformatf("v%0d_active", i), 32'(scan_active), 32'd1);
    end

    // Glitchy position 0 after the other three positions are captured
    hold(A1, P2, 1'b0, DWELL);
    hold(A2, PD, 1'b0, DWELL);
    hold(A3, PD, 1'b0, DWELL);
    snap();
    for (int t = 0; t < 4; t++) hold(A0, (t % 2 == 0) ? P8 : P3, 1'b0, 3);
    check("glitch_no_early_frame", 32'(fv_cnt - fv_snap), 32'd0);
    an_i = A0; seg_i = P5; dp_i = 1'b0;
    @(posedge clock);
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (frame_valid) break;
    end
    check("glitch_latency", 32'(n), 32'd10);
    repeat (DWELL) @(negedge clock);
    check("glitch_frames", 32'(fv_cnt - fv_snap), 32'd1);
    check("glitch_ones", 32'(ones), 32'd5);
    check("glitch_val", 32'(value_bin), 32'd25);

    // Invalid anode pattern mid-scan
    hold(A0, P1, 1'b0, DWELL);
    hold(A1, P2, 1'b0, DWELL);
    hold(A2, P3, 1'b0, DWELL);
    snap();
    hold(4'b1100, P8, 1'b0, DWELL);
    check("anode_err_once", 32'(ae_cnt - ae_snap), 32'd1);
    check("anode_no_frame", 32'(fv_cnt - fv_snap), 32'd0);
    snap();
    hold(AI, PB, 1'b1, DWELL);
    check("blank_no_anode_err", 32'(ae_cnt - ae_snap), 32'd0);
    hold(A3, P4, 1'b0, DWELL);
    check("anode_then_frame", 32'(fv_cnt - fv_snap), 32'd1);
    check("anode_frame_val", 32'(value_bin), 32'd21);

    // Back-to-back frames 29 then 30, then bus idle into timeout
    scan4(P9, P2, PB, PB, 4'b0000);
    check("b2b_val29", 32'(value_bin), 32'd29);
    scan4(P0, P3, PB, PB, 4'b0000);
    check("b2b_val30", 32'(value_bin), 32'd30);
    snap();
    hold(AI, PB, 1'b1, 990);
    check("idle_still_active", 32'(scan_active), 32'd1);
    hold(AI, PB, 1'b1, 100);
    check("timeout_inactive", 32'(scan_active), 32'd0);
    check("timeout_hold_val", 32'(value_bin), 32'd30);
    check("timeout_hold_tens", 32'(tens), 32'd3);
    check("timeout_no_frame", 32'(fv_cnt - fv_snap), 32'd0);

    // Reset in the middle of a scan discards the partial frame
    hold(A0, P1, 1'b0, DWELL);
    hold(A1, P2, 1'b0, DWELL);
    reset = 1'b1; an_i = AI; seg_i = PB; dp_i = 1'b1;
    #2;
    check_reset_state("midrst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    snap();
    hold(A2, P5, 1'b0, DWELL);
    hold(A3, P6, 1'b0, DWELL);
    check("midrst_no_frame", 32'(fv_cnt - fv_snap), 32'd0);
    hold(A0, P3, 1'b0, DWELL);
    hold(A1, P4, 1'b0, DWELL);
    check("midrst_frame", 32'(fv_cnt - fv_snap), 32'd1);
    check("midrst_val", 32'(value_bin), 32'd43);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
